uart_tx: RTL and testbench

Serial transmitter for the FPGA-to-PC link: accepts bytes over a valid/ready handshake, buffers them in a small FIFO, and shifts them out as 8N1 UART frames, LSB first. It is the counterpart of `uart_rx` on the same host link and is used to return solved puzzle data and status bytes to the PC. It runs at 100 MHz alongside the receiver.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_tx_fifo.sv | 65 ++++++
 rtl/uart_tx.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the host-link UART (uart_tx / uart_rx).
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } uart_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3
  } uart_state_e;
`endif

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the UART transmitter, pointers one bit wider than
// the address so full/empty are distinguished by the wrap bit.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // Next-pointer computation; push and pop on one edge both take effect.
  always_comb begin
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a byte FIFO in front of the shift FSM.
// Define UART_TX_PARITY_EN to insert an even-parity bit before STOP.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       axiiv,
  input  logic [7:0] axiid,
  output logic       axiir,
  output logic       axiod,
  output logic       busy
);

  localparam int                CW       = $clog2(CLKS_PER_BIT);
  localparam int                BW       = $clog2(DATA_BITS);
  localparam logic [CW-1:0]     CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]     BIT_LAST = BW'(DATA_BITS - 1);

  uart_state_e            state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   axiod_q, axiod_d;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic                   fifo_pop_s;
  logic                   push_s;
  logic [DATA_BITS-1:0]   fifo_dout_s;
  logic                   bit_end_s;

  assign axiir     = !fifo_full_s;
  assign push_s    = axiiv && !fifo_full_s;
  assign axiod     = axiod_q;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty_s;
  assign bit_end_s = (cnt_q == CNT_LAST);

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (fifo_pop_s),
    .din   (axiid),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Frame FSM; axiod_d is the line level for the cycle after this edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    axiod_d    = axiod_q;
    fifo_pop_s = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          shift_d    = fifo_dout_s;
`ifdef UART_TX_PARITY_EN
          parity_d   = even_parity(fifo_dout_s);
`endif
          state_d    = ST_START;
          axiod_d    = 1'b0;
        end else begin
          axiod_d    = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          bit_d   = '0;
          axiod_d = shift_q[0];
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            axiod_d = parity_q;
`else
            state_d = ST_STOP;
            axiod_d = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            axiod_d = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end_s) begin
          state_d = ST_STOP;
          cnt_d   = '0;
          axiod_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
`endif
      ST_STOP: begin
        if (bit_end_s) begin
          cnt_d = '0;
          bit_d = '0;
          // Chain straight into the next start bit so bursts have no gap.
          if (!fifo_empty_s) begin
            fifo_pop_s = 1'b1;
            shift_d    = fifo_dout_s;
`ifdef UART_TX_PARITY_EN
            parity_d   = even_parity(fifo_dout_s);
`endif
            state_d    = ST_START;
            axiod_d    = 1'b0;
          end else begin
            state_d    = ST_IDLE;
            axiod_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
        axiod_d = 1'b1;
      end
    endcase
  end

  // FSM, baud counter and line registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      axiod_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      axiod_q  <= axiod_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frames are predicted bit-by-bit from the
// byte stream and the FIFO occupancy is predicted from accept/start counts.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FC = CPB * NBITS;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       axiiv = 1'b0;
  logic [7:0] axiid = 8'h00;
  logic       axiir;
  logic       axiod;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] bytes_q [8];

  always #5 clk = ~clk;

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .axiiv (axiiv),
    .axiid (axiid),
    .axiir (axiir),
    .axiod (axiod),
    .busy  (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected line level for each of the FC cycles of one frame.
  function automatic logic [63:0] frame_bits(input logic [7:0] b);
    logic [63:0] r;
    int k;
    r = '0;
    for (int i = 0; i < FC; i++) begin
      k = i / CPB;
      if (k == 0)                    r[i] = 1'b0;
      else if (k <= 8)               r[i] = b[k-1];
      else if (NBITS == 11 && k == 9) r[i] = ^b;
      else                           r[i] = 1'b1;
    end
    return r;
  endfunction

  // Push bytes_q[0..n-1] with axiiv held high from an idle, empty transmitter.
  task automatic run_burst(input int n, input string name);
    logic [63:0] obs [8];
    logic [7:0]  exp_q [$];
    logic [7:0]  eb;
    logic [7:0]  dec;
    int acc, first, s_edge, starts, occ, bad_rdy;
    logic acc_now, saw_full, busy_pre, busy_post;
    acc = 0; first = -1; s_edge = 0; bad_rdy = 0;
    saw_full = 1'b0; busy_pre = 1'b0; busy_post = 1'b1;
    for (int f = 0; f < 8; f++) obs[f] = '0;
    axiiv = 1'b1;
    axiid = bytes_q[0];
    for (int t = 0; t < n * FC + 60; t++) begin
      acc_now = axiiv && axiir;
      tick();
      if (acc_now) begin
        if (acc == 0) first = t;
        exp_q.push_back(bytes_q[acc]);
        acc++;
        if (acc < n) axiid = bytes_q[acc];
        else         axiiv = 1'b0;
      end
      if (first >= 0) begin
        s_edge = first + 1;
        if (t < s_edge) starts = 0;
        else            starts = (t - s_edge) / FC + 1;
        if (starts > n) starts = n;
        occ = acc - starts;
        if (axiir !== (occ < DEPTH)) bad_rdy++;
        if (!axiir) saw_full = 1'b1;
        if (t >= s_edge && t < s_edge + n * FC)
          obs[(t - s_edge) / FC][(t - s_edge) % FC] = axiod;
        if (t == s_edge + n * FC - 1) busy_pre = busy;
        if (t == s_edge + n * FC)     busy_post = busy;
      end
    end
    axiiv = 1'b0;
    check_eq({name, "_ready_model"}, 64'(bad_rdy), 64'd0);
    if (n > DEPTH) check_eq({name, "_ready_dropped"}, 64'(saw_full), 64'd1);
    check_eq({name, "_busy_last_cycle"}, 64'(busy_pre), 64'd1);
    check_eq({name, "_busy_after"}, 64'(busy_post), 64'd0);
    check_eq({name, "_line_idle_after"}, 64'(axiod), 64'd1);
    for (int f = 0; f < n; f++) begin
      eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check_eq($sformatf("%s_frame%0d", name, f), obs[f], frame_bits(eb));
      for (int j = 0; j < 8; j++) dec[j] = obs[f][(j + 1) * CPB + CPB / 2];
      check_eq($sformatf("%s_rx_byte%0d", name, f), 64'(dec), 64'(eb));
`ifdef UART_TX_PARITY_EN
      check_eq($sformatf("%s_parity%0d", name, f), 64'(obs[f][9 * CPB + CPB / 2]), 64'(^eb));
`endif
    end
  endtask

  initial begin
    int bad;
    int n;

    // Reset state and quiet line.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_axiod", 64'(axiod), 64'd1);
    check_eq("reset_axiir", 64'(axiir), 64'd1);
    check_eq("reset_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      tick();
      if (axiod !== 1'b1 || busy !== 1'b0) bad++;
    end
    check_eq("idle_100_cycles", 64'(bad), 64'd0);

    bytes_q[0] = 8'hA5;
    run_burst(1, "single_a5");

    bytes_q[0] = 8'h00; bytes_q[1] = 8'hFF; bytes_q[2] = 8'h55;
    bytes_q[3] = 8'h81; bytes_q[4] = 8'h3C;
    run_burst(5, "burst5");

    // One more byte than the FIFO plus shifter can absorb: producer is held off.
    for (int i = 0; i < 6; i++) bytes_q[i] = 8'($urandom);
    run_burst(6, "holdoff6");

    // Reset asserted mid-frame with a second byte still buffered.
    axiid = 8'h0F; axiiv = 1'b1;
    tick();
    axiid = 8'hEE;
    tick();
    axiiv = 1'b0;
    repeat (17) tick();
    check_eq("midreset_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midreset_axiod", 64'(axiod), 64'd1);
    check_eq("midreset_busy", 64'(busy), 64'd0);
    check_eq("midreset_axiir", 64'(axiir), 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    bad = 0;
    repeat (50) begin
      tick();
      if (axiod !== 1'b1 || busy !== 1'b0) bad++;
    end
    check_eq("midreset_no_residue", 64'(bad), 64'd0);
    bytes_q[0] = 8'h42;
    run_burst(1, "after_reset_42");

    // Random bursts separated by random idle gaps.
    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) bytes_q[i] = 8'($urandom);
      repeat ($urandom_range(0, 20)) tick();
      run_burst(n, $sformatf("rand%0d", r));
    end

`ifdef UART_TX_PARITY_EN
    bytes_q[0] = 8'h07;
    run_burst(1, "parity_07");
    bytes_q[0] = 8'h03;
    run_burst(1, "parity_03");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
